// File: rtl/up_io_pkg.sv
// Shared definitions for the uP pushbutton input port: nibble width and the
// per-button debounce state encoding.
package up_io_pkg;

    localparam int UP_NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_LOW  = 2'd0,
        ST_RISE = 2'd1,
        ST_HIGH = 2'd2,
        ST_FALL = 2'd3
    } db_state_t;

endpackage

// File: rtl/up_debounce_bit.sv
// One button: two-flop synchroniser followed by a counting debounce FSM.
// Emits the stable level and a one-cycle pulse on the cycle a press is accepted.
module up_debounce_bit
    import up_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_button,
    output logic o_level,
    output logic o_press_pulse
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             w_s;
    db_state_t        r_state;
    db_state_t        w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    assign w_s = r_sync2;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= ST_LOW;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_button;
            r_sync2 <= r_sync1;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // The counter only advances while a candidate level is held; any bounce back restarts it.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_LOW: begin
                if (w_s) begin
                    w_state_next = ST_RISE;
                    w_cnt_next   = CNT_ONE;
                end else begin
                    w_cnt_next   = '0;
                end
            end
            ST_RISE: begin
                if (!w_s) begin
                    w_state_next = ST_LOW;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_next = ST_HIGH;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!w_s) begin
                    w_state_next = ST_FALL;
                    w_cnt_next   = CNT_ONE;
                end else begin
                    w_cnt_next   = '0;
                end
            end
            ST_FALL: begin
                if (w_s) begin
                    w_state_next = ST_HIGH;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_next = ST_LOW;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_next = ST_LOW;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        o_level       = (r_state == ST_HIGH) || (r_state == ST_FALL);
        o_press_pulse = (r_state == ST_RISE) && w_s && (r_cnt == CNT_MAX);
    end

endmodule

// File: rtl/up_pushbutton_port.sv
// Pushbutton input port for the 4-bit uP: debounced levels plus sticky press
// events, cleared by an edge-detected IN read during the execute phase.
// i_reset is asynchronous and active-low.
module up_pushbutton_port
    import up_io_pkg::*;
#(
    parameter int WIDTH           = UP_NIBBLE_W,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_pushbuttons,
    input  logic             i_phase,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_data_out,
    output logic [WIDTH-1:0] o_btn_level,
    output logic             o_event_pend,
    output logic             o_rd_ack
);

    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_press;
    logic [WIDTH-1:0] r_press_latch;
    logic             r_rd_prev;
    logic             r_rd_ack;
    logic             w_rd_req;
    logic             w_rd_accept;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        up_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .i_clock       (i_clock),
            .i_reset       (i_reset),
            .i_button      (i_pushbuttons[g]),
            .o_level       (w_level[g]),
            .o_press_pulse (w_press[g])
        );
    end

    assign w_rd_req    = i_rd_en & i_phase;
    assign w_rd_accept = w_rd_req & ~r_rd_prev;

    // A press landing on the read edge survives the clear so it is seen by the next read.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_press_latch <= '0;
            r_rd_prev     <= 1'b0;
            r_rd_ack      <= 1'b0;
        end else begin
            r_rd_prev     <= w_rd_req;
            r_rd_ack      <= w_rd_accept;
            r_press_latch <= w_rd_accept ? w_press : (r_press_latch | w_press);
        end
    end

    assign o_data_out   = w_level | r_press_latch;
    assign o_btn_level  = w_level;
    assign o_event_pend = |r_press_latch;
    assign o_rd_ack     = r_rd_ack;

endmodule

// File: tb/tb_up_pushbutton_port.sv
// Directed scenarios followed by random stimulus, all checked against a
// history-based behavioural model of the pushbutton port.
module tb_up_pushbutton_port;

    localparam int W  = 4;
    localparam int DB = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] pushbuttons = '0;
    logic         phase = 1'b0;
    logic         rdEn  = 1'b0;
    logic [W-1:0] dataOut;
    logic [W-1:0] btnLevel;
    logic         eventPend;
    logic         rdAck;

    int checks = 0;
    int errors = 0;
    int ackCount;

    logic [W-1:0] mSync1, mSync2, mLevel, mLatch;
    logic         mPrevRd, mAck;
    logic [W-1:0] mHist [DB];

    up_pushbutton_port #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (3)
    ) dut (
        .i_clock       (clock),
        .i_reset       (reset),
        .i_pushbuttons (pushbuttons),
        .i_phase       (phase),
        .i_rd_en       (rdEn),
        .o_data_out    (dataOut),
        .o_btn_level   (btnLevel),
        .o_event_pend  (eventPend),
        .o_rd_ack      (rdAck)
    );

    always #1 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mSync1  = '0;
        mSync2  = '0;
        mLevel  = '0;
        mLatch  = '0;
        mPrevRd = 1'b0;
        mAck    = 1'b0;
        for (int k = 0; k < DB; k++) mHist[k] = '0;
    endtask

    // A button's level flips once the last DB synchronised samples all disagree with it.
    task automatic modelEdge();
        logic [W-1:0] allOne, allZero, press;
        logic         rdNow, accept;
        for (int k = DB - 1; k > 0; k--) mHist[k] = mHist[k-1];
        mHist[0] = mSync2;
        allOne  = '1;
        allZero = '1;
        for (int k = 0; k < DB; k++) begin
            allOne  &= mHist[k];
            allZero &= ~mHist[k];
        end
        press   = ~mLevel & allOne;
        mLevel  = (mLevel & ~allZero) | (~mLevel & allOne);
        rdNow   = rdEn & phase;
        accept  = rdNow & ~mPrevRd;
        mLatch  = accept ? press : (mLatch | press);
        mAck    = accept;
        mPrevRd = rdNow;
        mSync2  = mSync1;
        mSync1  = pushbuttons;
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_data"},  32'(dataOut),   32'(mLevel | mLatch));
        checkOutput({tag, "_level"}, 32'(btnLevel),  32'(mLevel));
        checkOutput({tag, "_pend"},  32'(eventPend), 32'(|mLatch));
        checkOutput({tag, "_ack"},   32'(rdAck),     32'(mAck));
    endtask

    task automatic applyStimulus(input logic [W-1:0] pb, input logic rd, input logic ph, input string tag);
        pushbuttons = pb;
        rdEn        = rd;
        phase       = ph;
        @(posedge clock);
        if (reset) modelEdge();
        @(negedge clock);
        checkAll(tag);
    endtask

    task automatic holdReset(input int cycles, input logic [W-1:0] pb);
        reset = 1'b0;
        modelReset();
        repeat (cycles) applyStimulus(pb, 1'b0, 1'b0, "reset");
        reset = 1'b1;
    endtask

    initial begin
        @(negedge clock);
        holdReset(3, 4'b0110);
        checkOutput("reset_data", 32'(dataOut), 32'h0);
        checkOutput("reset_pend", 32'(eventPend), 32'h0);

        for (int k = 1; k <= 6; k++) begin
            applyStimulus(4'b0110, 1'b0, 1'b0, "press");
            if (k == 5) checkOutput("press_early_pend", 32'(eventPend), 32'h0);
        end
        checkOutput("press_level", 32'(btnLevel), 32'h6);
        checkOutput("press_pend", 32'(eventPend), 32'h1);
        checkOutput("press_data", 32'(dataOut), 32'h6);

        repeat (8) applyStimulus(4'b0000, 1'b0, 1'b0, "release");
        checkOutput("release_data", 32'(dataOut), 32'h6);
        applyStimulus(4'b0000, 1'b1, 1'b1, "read1");
        checkOutput("read1_ack", 32'(rdAck), 32'h1);
        checkOutput("read1_data", 32'(dataOut), 32'h0);
        applyStimulus(4'b0000, 1'b0, 1'b1, "read1_after");

        repeat (3) applyStimulus(4'b0001, 1'b0, 1'b0, "glitch");
        repeat (6) applyStimulus(4'b0000, 1'b0, 1'b0, "glitch");
        checkOutput("glitch_pend", 32'(eventPend), 32'h0);
        checkOutput("glitch_data", 32'(dataOut), 32'h0);

        repeat (6) applyStimulus(4'b0100, 1'b0, 1'b0, "sticky");
        repeat (6) applyStimulus(4'b0000, 1'b0, 1'b0, "sticky");
        checkOutput("sticky_data", 32'(dataOut), 32'h4);
        applyStimulus(4'b0000, 1'b1, 1'b1, "sticky_read");
        checkOutput("sticky_ack", 32'(rdAck), 32'h1);
        applyStimulus(4'b0000, 1'b0, 1'b1, "sticky_after");
        checkOutput("sticky_after_data", 32'(dataOut), 32'h0);
        checkOutput("sticky_after_pend", 32'(eventPend), 32'h0);

        repeat (6) applyStimulus(4'b0001, 1'b0, 1'b0, "coll_setup");
        repeat (6) applyStimulus(4'b0000, 1'b0, 1'b0, "coll_setup");
        repeat (5) applyStimulus(4'b1000, 1'b0, 1'b0, "coll_press");
        applyStimulus(4'b1000, 1'b1, 1'b1, "coll_edge");
        checkOutput("coll_ack", 32'(rdAck), 32'h1);
        checkOutput("coll_pend", 32'(eventPend), 32'h1);
        checkOutput("coll_data", 32'(dataOut), 32'h8);
        repeat (6) applyStimulus(4'b0000, 1'b0, 1'b0, "coll_release");
        checkOutput("coll_sticky_data", 32'(dataOut), 32'h8);
        applyStimulus(4'b0000, 1'b1, 1'b1, "coll_read2");
        checkOutput("coll_read2_data", 32'(dataOut), 32'h0);

        repeat (6) applyStimulus(4'b0010, 1'b0, 1'b0, "held_setup");
        repeat (6) applyStimulus(4'b0000, 1'b0, 1'b0, "held_setup");
        ackCount = 0;
        repeat (4) begin
            applyStimulus(4'b0000, 1'b1, 1'b1, "held_rd");
            ackCount += int'(rdAck);
        end
        applyStimulus(4'b0000, 1'b0, 1'b1, "held_end");
        ackCount += int'(rdAck);
        checkOutput("held_ack_count", 32'(ackCount), 32'd1);

        repeat (6) applyStimulus(4'b0010, 1'b0, 1'b0, "gate_setup");
        repeat (6) applyStimulus(4'b0000, 1'b0, 1'b0, "gate_setup");
        ackCount = 0;
        repeat (3) begin
            applyStimulus(4'b0000, 1'b1, 1'b0, "gate_rd");
            ackCount += int'(rdAck);
        end
        checkOutput("gate_ack_count", 32'(ackCount), 32'd0);
        checkOutput("gate_data", 32'(dataOut), 32'h2);
        checkOutput("gate_pend", 32'(eventPend), 32'h1);

        repeat (3) applyStimulus(4'b0001, 1'b0, 1'b0, "middb");
        holdReset(2, 4'b0001);
        repeat (6) applyStimulus(4'b0001, 1'b0, 1'b0, "middb_after");
        checkOutput("middb_pend", 32'(eventPend), 32'h1);

        for (int n = 0; n < 500; n++) begin
            logic [W-1:0] pb;
            pb = pushbuttons;
            if ($urandom_range(0, 7) == 0) pb = W'($urandom);
            if ($urandom_range(0, 149) == 0) holdReset($urandom_range(1, 3), pb);
            applyStimulus(pb, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
